tick_divider: RTL and testbench
===============================

Name: tick_divider

Overview:
- Programmable clock-enable generator feeding the LED/pin toggling stage on the TinyFPGA BX.
- Divides the 16 MHz CLK by a runtime-loadable divisor.
- Outputs a one-cycle tick pulse, a 50% square wave and a wrapping tick count.
- Downstream logic runs in the CLK domain and is gated by tick; no derived clocks are used.

Parameters:
- WIDTH, 24, divisor/counter width in bits.
- DIV_DEFAULT, 8000000, divisor after reset (clk_out = 1 Hz at 16 MHz); must be < 2^WIDTH.
- CNT_WIDTH, 8, width of tick_count.

Ports:
- CLK  input  1  system clock, 16 MHz.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low forces STOP.
- div_in  input  WIDTH  new divisor value.
- div_valid  input  1  div_in is valid this cycle.
- div_ready  output  1  block can accept a divisor.
- tick  output  1  one-CLK pulse every div_cur cycles while running.
- clk_out  output  1  square wave toggling on every tick (period 2*div_cur).
- tick_count  output  CNT_WIDTH  number of ticks since reset/STOP, wraps.
- running  output  1  high in RUN state.

Behaviour:
- Reset (async, any time, including mid-load): state=STOP, div_cur=DIV_DEFAULT, pending empty, counter=0, tick=0, clk_out=0, tick_count=0, running=0, div_ready=1.
- All outputs are registered.
- Handshake:
  - Transfer occurs when div_valid & div_ready at a rising CLK edge.
  - div_ready = !pend_valid.
  - In STOP, an accepted value is written to div_cur directly on that edge; pending stays empty.
  - In RUN, an accepted value goes to pend_div with pend_valid=1.
  - pend_div is applied at the next terminal count: div_cur<=pend_div and pend_valid<=0 on the tick edge, so the new period starts with the following count.
  - The period in flight is never truncated or stretched, so clk_out has no glitch.
  - div_in is ignored while div_ready=0.
- Divisor 0 means halt: treated as STOP regardless of en; div_cur=0 is stored normally.
- States:
  - STOP: counter held at 0; tick=0; clk_out=0; tick_count=0; running=0.
    - STOP->RUN when en=1 and div_cur!=0.
    - On entry, counter<=div_cur-1.
  - RUN: counter decrements each cycle.
    - When counter==0: tick=1 in the following cycle (registered), clk_out toggles with tick, tick_count increments mod 2^CNT_WIDTH, and counter reloads to (next div_cur)-1.
    - RUN->STOP when en=0, or when a terminal count applies a pending divisor of 0.
    - On exit: pending is discarded if nonzero, clk_out/tick_count cleared next cycle, and a tick already registered is still output.
- Latency:
  - First tick asserts exactly div_cur cycles after the first cycle running=1.
  - Subsequent ticks are spaced exactly div_cur cycles.
  - div_cur=1: tick held high every cycle, clk_out = CLK/2.
- Simultaneous events:
  - en falling on the same edge as terminal count: that tick is emitted, then STOP.
  - A load accepted on the terminal-count edge in RUN goes to pending and applies at the next terminal count, not the current one.
  - A load accepted on the same edge as en rising from STOP is written to div_cur and used for the RUN entry load.
- Arithmetic: counter is unsigned WIDTH bits; div_cur-1 is never computed with div_cur=0.

Test Plan:
1. DIV_DEFAULT=4, reset pulse mid-cycle then en=1 -> running=1 next edge; tick pulses every 4 cycles, the first 4 cycles after running; clk_out period 8; tick_count 0,1,2,...
2. RUN with div 4, load div_in=2 two cycles before terminal count -> div_ready drops; current period stays 4; subsequent ticks spaced 2; div_ready rises on the tick edge.
3. div_in=1 in STOP then en=1 -> tick continuously high; clk_out toggles every CLK.
4. Load div_in=0 while RUN -> final tick at the current terminal count, then running=0 and clk_out=0; raising en again gives no ticks until a nonzero divisor is loaded.
5. en deasserted on the terminal-count cycle with DIV=3 -> the tick is still emitted; STOP follows, tick_count=0, clk_out=0; re-enable gives its first tick 3 cycles later.
6. Assert reset during pending load (pend_valid=1, CNT_WIDTH=8 after 255 ticks) -> all outputs 0 immediately; div_cur=DIV_DEFAULT; pending cleared; without reset, the 256th tick wraps tick_count to 0.

Source files
------------

// File: rtl/tick_divider.sv
// Programmable clock-enable divider: one-cycle tick every div_cur CLK cycles,
// a square wave toggling on each tick and a wrapping tick counter.
module tick_divider #(
  parameter int WIDTH       = 24,
  parameter int DIV_DEFAULT = 8000000,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     div_in,
  input  logic                 div_valid,
  output logic                 div_ready,
  output logic                 tick,
  output logic                 clk_out,
  output logic [CNT_WIDTH-1:0] tick_count,
  output logic                 running
);

  // state | meaning
  // STOP  | idle: counter 0, outputs cleared, divisor loads go straight to div_cur
  // RUN   | counter decrements; terminal count emits tick and applies a pending divisor
  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_counter, w_counter_nxt;
  logic [WIDTH-1:0]     r_div_cur, w_div_cur_nxt;
  logic [WIDTH-1:0]     r_pend_div, w_pend_div_nxt;
  logic                 r_pend_valid, w_pend_valid_nxt;
  logic                 r_tick, w_tick_nxt;
  logic                 r_clk_out, w_clk_out_nxt;
  logic [CNT_WIDTH-1:0] r_tick_count, w_tick_count_nxt;
  logic                 r_running;
  logic                 w_accept;
  logic                 w_tc;

  assign w_accept = div_valid && !r_pend_valid;
  assign w_tc     = (r_state == ST_RUN) && (r_counter == '0);

  always_comb begin
    w_state_nxt      = r_state;
    w_counter_nxt    = r_counter;
    w_div_cur_nxt    = r_div_cur;
    w_pend_div_nxt   = r_pend_div;
    w_pend_valid_nxt = r_pend_valid;
    w_tick_nxt       = 1'b0;
    w_clk_out_nxt    = r_clk_out;
    w_tick_count_nxt = r_tick_count;
    case (r_state)
      ST_STOP: begin
        w_clk_out_nxt    = 1'b0;
        w_tick_count_nxt = '0;
        w_counter_nxt    = '0;
        w_pend_valid_nxt = 1'b0;
        if (w_accept) w_div_cur_nxt = div_in;
        // a divisor loaded on the enabling edge is the one used for the entry load
        if (en && (w_div_cur_nxt != '0)) begin
          w_state_nxt   = ST_RUN;
          w_counter_nxt = w_div_cur_nxt - WIDTH'(1);
        end
      end
      ST_RUN: begin
        w_tick_nxt = w_tc;
        if (w_tc) begin
          w_clk_out_nxt    = ~r_clk_out;
          w_tick_count_nxt = r_tick_count + CNT_WIDTH'(1);
          if (r_pend_valid) begin
            w_div_cur_nxt    = r_pend_div;
            w_pend_valid_nxt = 1'b0;
          end
          if (w_div_cur_nxt != '0) w_counter_nxt = w_div_cur_nxt - WIDTH'(1);
        end else begin
          w_counter_nxt = r_counter - WIDTH'(1);
        end
        if (w_accept) begin
          w_pend_div_nxt   = div_in;
          w_pend_valid_nxt = 1'b1;
        end
        // a zero divisor halts; the tick of this edge (if any) is still emitted
        if (!en || (w_div_cur_nxt == '0)) begin
          w_state_nxt      = ST_STOP;
          w_counter_nxt    = '0;
          w_pend_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state      <= ST_STOP;
      r_counter    <= '0;
      r_div_cur    <= WIDTH'(DIV_DEFAULT);
      r_pend_div   <= '0;
      r_pend_valid <= 1'b0;
      r_tick       <= 1'b0;
      r_clk_out    <= 1'b0;
      r_tick_count <= '0;
      r_running    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_counter    <= w_counter_nxt;
      r_div_cur    <= w_div_cur_nxt;
      r_pend_div   <= w_pend_div_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_tick       <= w_tick_nxt;
      r_clk_out    <= w_clk_out_nxt;
      r_tick_count <= w_tick_count_nxt;
      r_running    <= (w_state_nxt == ST_RUN);
    end
  end

  assign div_ready  = !r_pend_valid;
  assign tick       = r_tick;
  assign clk_out    = r_clk_out;
  assign tick_count = r_tick_count;
  assign running    = r_running;

endmodule

// File: tb/tb_tick_divider.sv
// Bench for tick_divider: directed scenarios plus random traffic, checked every
// cycle against an elapsed-cycle reference model of the divider.
`timescale 1ns/1ps
module tb_tick_divider;

  localparam int WIDTH = 24;
  localparam int DIV_DEF = 4;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] div_in = '0;
  logic             div_valid = 1'b0;
  logic             div_ready;
  logic             tick;
  logic             clk_out;
  logic [CNT_W-1:0] tick_count;
  logic             running;

  int n_pass = 0;
  int n_total = 0;

  // reference model: periods measured as cycles elapsed since run start / last tick
  bit          m_run;
  int unsigned m_div;
  int unsigned m_pend[$];
  int          m_el;
  bit          m_tick;
  bit          m_clk;
  int          m_cnt;

  tick_divider #(.WIDTH(WIDTH), .DIV_DEFAULT(DIV_DEF), .CNT_WIDTH(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .en(en), .div_in(div_in), .div_valid(div_valid),
    .div_ready(div_ready), .tick(tick), .clk_out(clk_out),
    .tick_count(tick_count), .running(running)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_div = DIV_DEF; m_pend.delete(); m_el = 0;
    m_tick = 0; m_clk = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit e, input bit v, input int unsigned d);
    bit acc;
    acc = v && (m_pend.size() == 0);
    if (!m_run) begin
      m_tick = 0; m_clk = 0; m_cnt = 0;
      if (acc) m_div = d;
      if (e && m_div != 0) begin m_run = 1; m_el = 0; end
    end else begin
      m_el++;
      if (m_el == int'(m_div)) begin
        m_tick = 1; m_clk = !m_clk; m_cnt = (m_cnt + 1) % 256; m_el = 0;
        if (m_pend.size() != 0) m_div = m_pend.pop_front();
      end else begin
        m_tick = 0;
      end
      if (acc) m_pend.push_back(d);
      if (!e || m_div == 0) begin m_run = 0; m_pend.delete(); end
    end
  endtask

  task automatic compare_all();
    check_eq("tick", 32'(tick), 32'(m_tick));
    check_eq("clk_out", 32'(clk_out), 32'(m_clk));
    check_eq("tick_count", 32'(tick_count), 32'(m_cnt));
    check_eq("running", 32'(running), 32'(m_run));
    check_eq("div_ready", 32'(div_ready), 32'(m_pend.size() == 0));
  endtask

  task automatic step(input bit e, input bit v, input int unsigned d);
    @(negedge CLK);
    en = e; div_valid = v; div_in = d[WIDTH-1:0];
    @(posedge CLK);
    model_edge(e, v, d);
    #1;
    compare_all();
  endtask

  // asynchronous reset asserted between edges; outputs must clear immediately
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_clk_out", 32'(clk_out), 32'd0);
    check_eq("rst_count", 32'(tick_count), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_ready", 32'(div_ready), 32'd1);
    model_reset();
    en = 1'b0; div_valid = 1'b0;
    @(posedge CLK);
    #2 reset = 1'b0;
  endtask

  task automatic run_to_tc(input bit e_at_tc);
    int guard = 0;
    while (!(m_run && (m_el + 1 == int'(m_div))) && guard < 50) begin
      step(1, 0, 0);
      guard++;
    end
    check_eq("tc_reached", 32'(guard < 50), 32'd1);
    step(e_at_tc, 0, 0);
  endtask

  initial begin
    model_reset();
    #13;
    pulse_reset();

    // default divisor 4 running
    for (int i = 0; i < 20; i++) step(1, 0, 0);

    // load 2 while running, two cycles before terminal count
    while (!(m_run && (m_el + 3 == int'(m_div)))) step(1, 0, 0);
    step(1, 1, 2);
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // divisor 1 loaded in STOP
    step(0, 0, 0);
    step(0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0);

    // divisor 0 loaded while running halts; no ticks until nonzero divisor
    step(1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    step(1, 1, 3);
    for (int i = 0; i < 8; i++) step(1, 0, 0);

    // en dropped exactly on terminal count with divisor 3
    run_to_tc(0);
    check_eq("tc_stop_tick", 32'(tick), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0);

    // 255 ticks at divisor 1, load on the 256th tick edge, then reset while pending
    step(0, 0, 0);
    step(0, 1, 1);
    for (int i = 0; i < 256; i++) step(1, 0, 0);
    check_eq("count_255", 32'(tick_count), 32'd255);
    step(1, 1, 5);
    check_eq("wrap", 32'(tick_count), 32'd0);
    check_eq("pend_ready", 32'(div_ready), 32'd0);
    pulse_reset();
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit e, v;
      int unsigned d;
      e = ($urandom_range(0, 15) != 0);
      v = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      step(e, v, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
